ahb_apb_bridge_param: RTL

Parametrised second-generation AHB-Lite to APB bridge. It adds configurable address/data width, N-slave one-hot address decode, and APB wait states via p_ready. It maps p_slverr, decode misses and access timeouts onto the AHB two-cycle ERROR response. It sits between the AHB interconnect slave port and the APB peripheral cluster.

---
 rtl/apb_bridge_pkg.sv | 20 ++
 rtl/apb_addr_decoder.sv | 31 +++
 rtl/ahb_apb_bridge_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// AHB-Lite to APB bridge shared definitions.
// FSM state codes, HTRANS encodings and HRESP values.
package apb_bridge_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_addr_decoder.sv
// One-hot APB slave decode over equal 2^SLV_AW windows.
// Purely combinational; misses yield sel=0, hit=0.
module apb_addr_decoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_SLV   = 4,
  parameter int unsigned       SLV_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       IDX_W     =
    (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic [IDX_W-1:0]   idx,
  output logic               hit
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] win;

  // addresses below BASE_ADDR wrap to a huge offset and miss
  always_comb begin
    off = addr - BASE_ADDR;
    win = off >> SLV_AW;
    hit = (win < ADDR_W'(NUM_SLV));
    idx = IDX_W'(win);
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      sel[i] = hit && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// Parametrised AHB-Lite to APB bridge with wait states,
// slave-error, decode-miss and timeout mapped to AHB ERROR.
module ahb_apb_bridge_param
  import apb_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SLV   = 4,
  parameter int unsigned       SLV_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       TIMEOUT   = 16
) (
  input  logic                      h_clk,
  input  logic                      h_reset,
  input  logic                      h_sel,
  input  logic [1:0]                h_trans,
  input  logic                      h_write,
  input  logic [ADDR_W-1:0]         h_addr,
  input  logic [DATA_W-1:0]         h_wdata,
  input  logic                      h_ready_in,
  output logic                      h_readyout,
  output logic                      h_resp,
  output logic [DATA_W-1:0]         h_rdata,
  output logic [ADDR_W-1:0]         p_addr,
  output logic [DATA_W-1:0]         p_wdata,
  output logic                      p_write,
  output logic [NUM_SLV-1:0]        p_selx,
  output logic                      p_enable,
  input  logic [NUM_SLV*DATA_W-1:0] p_rdata,
  input  logic [NUM_SLV-1:0]        p_ready,
  input  logic [NUM_SLV-1:0]        p_slverr
);

  localparam int unsigned IDX_W =
    (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic               hit_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_SLV-1:0] sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_SLV-1:0] dec_sel;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_hit;

  logic              take;
  logic              rdy;
  logic              err;
  logic              tmo;
  logic [DATA_W-1:0] rdata_s;

  apb_addr_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .SLV_AW    (SLV_AW),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr (h_addr),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  // new address phase is legal whenever HREADYOUT is high
  always_comb begin
    take = h_sel && h_ready_in
        && (h_trans == HTRANS_NONSEQ || h_trans == HTRANS_SEQ)
        && (state == S_IDLE || state == S_ERR2);
    rdy     = p_ready[idx_q];
    err     = p_slverr[idx_q];
    rdata_s = p_rdata[idx_q*DATA_W +: DATA_W];
    tmo     = (TIMEOUT != 0) && (cnt == CNT_LAST);
  end

  always_ff @(posedge h_clk or negedge h_reset) begin
    if (!h_reset) begin
      state      <= S_IDLE;
      h_readyout <= 1'b1;
      h_resp     <= HRESP_OKAY;
      h_rdata    <= '0;
      p_addr     <= '0;
      p_wdata    <= '0;
      p_write    <= 1'b0;
      p_selx     <= '0;
      p_enable   <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      sel_q      <= '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LATCH: begin
          if (hit_q) begin
            state   <= S_SETUP;
            p_selx  <= sel_q;
            p_addr  <= addr_q;
            p_write <= write_q;
            if (write_q) p_wdata <= h_wdata;
          end else begin
            state  <= S_ERR1;
            h_resp <= HRESP_ERROR;
          end
        end
        S_SETUP: begin
          state    <= S_ACCESS;
          p_enable <= 1'b1;
          cnt      <= '0;
        end
        S_ACCESS: begin
          if (rdy || tmo) begin
            p_selx   <= '0;
            p_enable <= 1'b0;
            if (rdy && !err) begin
              state      <= S_IDLE;
              h_readyout <= 1'b1;
              if (!write_q) h_rdata <= rdata_s;
            end else begin
              state  <= S_ERR1;
              h_resp <= HRESP_ERROR;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          h_readyout <= 1'b1;
        end
        S_ERR2: begin
          state  <= S_IDLE;
          h_resp <= HRESP_OKAY;
        end
        default: state <= S_IDLE;
      endcase
      if (take) begin
        state      <= S_LATCH;
        h_readyout <= 1'b0;
        addr_q     <= h_addr;
        write_q    <= h_write;
        hit_q      <= dec_hit;
        idx_q      <= dec_idx;
        sel_q      <= dec_sel;
      end
    end
  end

endmodule
